// File: rtl/instr_fetch_pkg.sv
// ============================================================================
// Module   : instr_fetch_pkg
// Brief    : Shared fetch-stage types and constants (state encoding, widths,
//            default reset PC and halt word).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [PC_W-1:0]    DEFAULT_RESET_PC  = 8'h00;
  localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  // Program counter increment; wraps FF -> 00 by width truncation.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : Program-ROM fetch stage: PC, one-entry instruction slot with
//            valid/ready handoff to decode, redirect, halt and restart.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [PC_W-1:0]    rom_address,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_addr,
  output logic               halted
);

  fetch_state_t       r_state,    w_state_nxt;
  logic [PC_W-1:0]    r_pc,       w_pc_nxt;
  logic [INSTR_W-1:0] r_instr,    w_instr_nxt;
  logic [PC_W-1:0]    r_instr_pc, w_instr_pc_nxt;
  logic               r_valid,    w_valid_nxt;
  logic               w_slot_free;

  assign w_slot_free = !r_valid || instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = RESET_PC;
        end
      end
      ST_RUN: begin
        // A redirect flushes the slot even if decode takes the word this cycle.
        if (redirect) begin
          w_valid_nxt = 1'b0;
          w_pc_nxt    = redirect_addr;
        end else if (w_slot_free) begin
          w_instr_nxt    = rom_data;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          if (rom_data == HALT_WORD) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt = pc_inc(r_pc);
          end
        end
      end
      ST_HALT: begin
        if (redirect) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = redirect_addr;
          w_valid_nxt = 1'b0;
        end else if (start) begin
          w_state_nxt = ST_RUN;
          w_pc_nxt    = RESET_PC;
          w_valid_nxt = 1'b0;
        end else if (instr_ready) begin
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign rom_address = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign halted      = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Initiator side of the 8-bit-address / 16-bit-data program ROM interface. Holds the program counter, drives the ROM address, and registers the returned word into a one-entry instruction slot. The slot is handed to decode with a valid/ready handshake. Supports branch/jump redirect, halt detection and restart; sits between the program ROM and the decode stage of the CPU.

Parameters:
RESET_PC, 8'h00, PC value at reset and on start/restart
HALT_WORD, 16'hFFFF, fetched word that stops fetching after it is delivered

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: begin fetching at RESET_PC (IDLE or HALT only)
rom_address  output  8  address to program ROM; combinational copy of pc
rom_data  input  16  ROM word for rom_address, combinational same cycle
instr  output  16  registered instruction word
instr_pc  output  8  address instr was fetched from
instr_valid  output  1  instr/instr_pc hold a valid word
instr_ready  input  1  decode accepts the word this cycle
redirect  input  1  branch/jump taken: flush slot, load pc
redirect_addr  input  8  new pc when redirect=1
halted  output  1  high while in HALT

Behaviour:
- One clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, pc=RESET_PC (so rom_address=RESET_PC), instr=16'h0000, instr_pc=8'h00, instr_valid=0, halted=0.
- States: IDLE, RUN, HALT. halted=1 exactly in HALT.
- IDLE: no fetch, instr_valid=0. start=1 -> RUN with pc=RESET_PC. redirect is ignored.
- RUN, evaluated each edge in this priority order:
  1. redirect=1: instr_valid<=0 (flush; a word handshaken this same cycle counts as consumed), pc<=redirect_addr, no load.
  2. Slot free (instr_valid=0 or instr_ready=1): instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (8-bit wrap, FF->00). If rom_data==HALT_WORD, the word is still loaded and delivered, then state<=HALT and pc holds.
  3. Slot occupied and instr_ready=0: hold everything (stall). pc does not advance.
- HALT: no fetch.
  - instr_valid clears on the cycle instr_ready=1 (halt word consumed).
  - redirect=1 -> RUN, pc<=redirect_addr, instr_valid<=0.
  - Otherwise start=1 -> RUN, pc<=RESET_PC, instr_valid<=0.
  - redirect wins over start.
- start in RUN is ignored.
- Latency:
  - start at edge N: RUN at N+1, first valid word at N+2.
  - redirect sampled at edge N: rom_address=redirect_addr after N, target word valid after N+1.
  - Steady state with instr_ready=1: one word per cycle.
- Reset asserted mid-operation: immediate return to reset values, including dropping instr_valid asynchronously.
- instr/instr_pc are unchanged whenever instr_valid=0 and no load occurs (no X).

Decomposition:
- Shared cpu package: state encoding (IDLE/RUN/HALT), PC_W=8, INSTR_W=16, default RESET_PC and HALT_WORD constants.
- No sub-module needed; the pc incrementer is inline. Benches instantiate the existing program ROM as the responder.

Test Plan:
- Reset then start, instr_ready=1 -> words 0F0F@00, F0F0@01, 3333@02, CCCC@03 on consecutive cycles, first valid two cycles after start.
- Stall: hold instr_ready=0 while instr=3333@02 for 3 cycles -> instr, instr_pc and rom_address=03 stable; release -> CCCC@03 next cycle, no word skipped or duplicated.
- Redirect to FD while F0F0@01 is valid -> next cycle instr_valid=0, then 00FF@FD, FF00@FE, FFFF@FF; halted=1 after FFFF is loaded; instr_valid drops after the handshake.
- In HALT, assert start -> restart: 0F0F@00 delivered two cycles later, halted=0. Separately, redirect in HALT to 04 -> 5555@04.
- HALT_WORD=16'h5555, redirect to FE -> FF00@FE, FFFF@FF, 0F0F@00 (pc wrap), then F0F0, 3333, CCCC, 5555@04 -> HALT.
- Assert reset while instr_valid=1 mid-stream -> instr_valid=0 and rom_address=00 without a clock edge; state IDLE until start.
